// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the
// instruction-fetch port (read-only) and the MEM-stage data port (lw/sw).
// Data requests win ties (older instruction); a pending fetch is guaranteed
// a grant after MAX_D_BURST consecutive data grants.
// Optional build macro: PERF_CNT_EN adds perf_if_wait / perf_d_wait stall
// cycle counters.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    // memory side
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]   perf_if_wait,
    output logic [31:0]   perf_d_wait
`endif
);

    localparam int SW = $clog2(MAX_D_BURST + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic          fetch_starved;
    logic          d_win;

    // A fetch that has waited through a full data burst blocks further data grants.
    assign fetch_starved = if_req && (streak == STREAK_MAX);
    assign d_win         = d_req && !fetch_starved;

    // Stalls are combinational so the pipeline registers release in the ack cycle.
    assign if_stall = if_req && !if_ack;
    assign d_stall  = d_req && !d_ack;

    // Arbitration FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            streak   <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register in this block
            // sees the pre-edge values of the others, independent of order.
            case (state)
                IDLE: begin
                    if (d_win) begin
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        if (streak != STREAK_MAX) begin
                            streak <= streak + 1'b1;
                        end
                        state   <= GNT_D;
                    end else if (if_req) begin
                        m_req  <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= if_addr;
                        streak <= '0;
                        state  <= GNT_IF;
                    end
                end
                GNT_IF: begin
                    if (m_ack) begin
                        m_req    <= 1'b0;
                        if_rdata <= m_rdata;
                        if_ack   <= 1'b1;
                        state    <= DONE;
                    end
                end
                GNT_D: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        // stores leave the last load result untouched
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                        d_ack <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // requests are deliberately not sampled here, so a requester
                    // dropping req in its ack cycle is never re-granted
                    if_ack <= 1'b0;
                    d_ack  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    // Free-running stall-cycle counters; wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_wait <= '0;
            perf_d_wait  <= '0;
        end else begin
            if (if_stall) perf_if_wait <= perf_if_wait + 32'd1;
            if (d_stall)  perf_d_wait  <= perf_d_wait + 32'd1;
        end
    end
`endif

endmodule
